cfs_rx_ctrl: RTL and testbench
==============================

# cfs_rx_ctrl

Receive-side controller of the Aligner, sitting between the MD RX slave interface and the RX FIFO, directly upstream of the register block. It checks each incoming MD transfer for a legal offset/size pair. Legal transfers go into the RX FIFO; illegal ones are dropped and counted. The drop counter drives `status_cnt_drop` and `max_drop` into the register block and is cleared by `ctrl_clr`.

## Interface
- `ALGN_DATA_WIDTH`, 32: MD data width in bits; must be ≥8 and a power of 2. `BYTES = ALGN_DATA_WIDTH/8`.
- `STATUS_CNT_DROP_WIDTH`, 8: drop counter width.
- Derived `OFFSET_W = (ALGN_DATA_WIDTH<=8) ? 1 : $clog2(BYTES)`.
- Derived `SIZE_W = $clog2(BYTES)+1`.

Ports:
- `pclk` in 1: clock.
- `presetn` in 1: reset, asynchronous, active-low; clock `pclk`.
- `md_rx_valid` in 1: MD transfer request.
- `md_rx_data` in ALGN_DATA_WIDTH: MD data.
- `md_rx_offset` in OFFSET_W: byte offset of the first valid byte.
- `md_rx_size` in SIZE_W: number of valid bytes.
- `md_rx_ready` out 1: one-cycle acknowledge.
- `md_rx_err` out 1: error flag, valid only while `md_rx_ready`=1.
- `push_valid` out 1: RX FIFO push request.
- `push_data` out ALGN_DATA_WIDTH: data pushed to the FIFO.
- `push_offset` out OFFSET_W: offset pushed to the FIFO.
- `push_size` out SIZE_W: size pushed to the FIFO.
- `push_ready` in 1: FIFO accepts the push (not full).
- `ctrl_clr` in 1: one-cycle pulse that clears the drop counter.
- `status_cnt_drop` out STATUS_CNT_DROP_WIDTH: drop count.
- `max_drop` out 1: high while `status_cnt_drop` equals all-ones.

## Operation
- **Legality**: a transfer is legal when all three hold:
  - `size != 0`;
  - `offset + size <= BYTES`, computed at SIZE_W+1 bits, no truncation;
  - `(BYTES + offset) % size == 0`.
- **FSM states**: IDLE, PUSH, RSP.
- **IDLE**: when `md_rx_valid`=1, capture data/offset/size into the push registers.
  - Illegal transfer → go to RSP with err=1 and increment the drop counter.
  - Legal transfer → go to PUSH.
- **PUSH**: `push_valid`=1 with the captured values held stable. When `push_ready`=1, go to RSP with err=0.
- **RSP**: drive `md_rx_ready`=1 and `md_rx_err` for exactly one cycle, then return to IDLE.
- **MD master contract**: the master holds valid, data, offset and size stable until it sees ready. Inputs are sampled only in IDLE.
- **Drop counter**:
  - `ctrl_clr`=1 sets it to 0 next cycle.
  - `ctrl_clr` takes priority over a same-cycle increment: the result is 0 and that drop is not counted.
  - At all-ones, behaviour depends on `CFS_RX_CTRL_DROP_SAT_EN` (see Configuration).
- **`max_drop`**: combinational compare of the counter against all-ones.
- **Data path**: `push_data`, `push_offset` and `push_size` are registered copies of the captured MD inputs, not recomputed.

## Timing
- **Reset values**: state=IDLE; `md_rx_ready`=0, `md_rx_err`=0, `push_valid`=0, `push_data`=0, `push_offset`=0, `push_size`=0, `status_cnt_drop`=0, `max_drop`=0.
- **Illegal transfer**: valid sampled in cycle N → `md_rx_ready`=1, `md_rx_err`=1 in cycle N+1. The counter shows the new value in N+1.
- **Legal transfer, FIFO not full**: `push_valid`=1 in N+1. With `push_ready`=1 in N+1, `md_rx_ready`=1, err=0 in N+2.
- **FIFO full**: `push_valid` stays high and values stay stable until `push_ready`. The ack follows one cycle after the push is accepted. No timeout.
- **Back-to-back transfers**: the earliest a new transfer can be sampled is the cycle after RSP (IDLE). Minimum spacing is 2 cycles for illegal transfers and 3 for legal ones.
- **Reset mid-transfer**: the FSM returns to IDLE asynchronously. No ack and no push are issued, and the counter goes to 0.
- **`ctrl_clr` during PUSH/RSP**: clears only the counter; the transfer completes normally.

## Configuration
- `CFS_RX_CTRL_DROP_SAT_EN` defined: the counter saturates at all-ones, and further drops leave it unchanged with `max_drop` held high.
- Undefined: the counter wraps from all-ones to 0, and `max_drop` falls on the wrap.

## Test plan
- **Legal transfer, FIFO ready**: BYTES=4, offset=1, size=1, data=0xAABBCCDD, `push_ready`=1 → `push_valid`=1 with the same values at N+1; ready=1, err=0 at N+2; count=0.
- **Illegal transfers**: size=0, then offset=1/size=2, then offset=3/size=2 → each acked at N+1 with err=1, no push; count goes 1, 2, 3.
- **FIFO backpressure**: legal offset=0, size=4, `push_ready`=0 for 5 cycles → `push_valid` held 5 cycles with stable data; ack one cycle after `push_ready`=1.
- **Saturate/wrap**: 256 illegal transfers with width 8 → with the macro, count=255 and `max_drop`=1 remain; without the macro, count=0 and `max_drop`=0.
- **Clear vs drop**: `ctrl_clr` pulsed in the same cycle as an illegal-transfer increment from count=5 → count=0; the following illegal transfer gives count=1.
- **Reset in PUSH**: reset with `push_ready`=0 → all outputs 0 asynchronously; after release, a new legal transfer completes with standard latency.

Source files
------------

// File: rtl/cfs_rx_ctrl.sv
// cfs_rx_ctrl: checks MD RX transfers for a legal offset/size pair, pushes legal ones to the RX FIFO and counts drops.
// Optional macro CFS_RX_CTRL_DROP_SAT_EN: drop counter saturates instead of wrapping.
`timescale 1ns/1ps
`default_nettype none

module cfs_rx_ctrl #(
    parameter  int ALGN_DATA_WIDTH       = 32,
    parameter  int STATUS_CNT_DROP_WIDTH = 8,
    localparam int BYTES                 = ALGN_DATA_WIDTH / 8,
    localparam int OFFSET_W              = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES),
    localparam int SIZE_W                = $clog2(BYTES) + 1
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             md_rx_valid,
    input  logic [ALGN_DATA_WIDTH-1:0]       md_rx_data,
    input  logic [OFFSET_W-1:0]              md_rx_offset,
    input  logic [SIZE_W-1:0]                md_rx_size,
    output logic                             md_rx_ready,
    output logic                             md_rx_err,
    output logic                             push_valid,
    output logic [ALGN_DATA_WIDTH-1:0]       push_data,
    output logic [OFFSET_W-1:0]              push_offset,
    output logic [SIZE_W-1:0]                push_size,
    input  logic                             push_ready,
    input  logic                             ctrl_clr,
    output logic [STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
    output logic                             max_drop
);

    localparam int                               CW        = SIZE_W + 1;
    localparam logic [CW-1:0]                    C_BYTES   = CW'(BYTES);
    localparam logic [CW-1:0]                    C_DIV_ONE = CW'(1);
    localparam logic [STATUS_CNT_DROP_WIDTH-1:0] C_CNT_ONE = STATUS_CNT_DROP_WIDTH'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PUSH = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    logic [1:0]                       r_state;
    logic                             r_err;
    logic [ALGN_DATA_WIDTH-1:0]       r_data;
    logic [OFFSET_W-1:0]              r_offset;
    logic [SIZE_W-1:0]                r_size;
    logic [STATUS_CNT_DROP_WIDTH-1:0] r_cnt;

    logic [CW-1:0] w_offset_ext;
    logic [CW-1:0] w_size_ext;
    logic [CW-1:0] w_end;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_div;
    logic          w_legal;
    logic          w_drop;

    // Extra bit on all terms so offset+size and BYTES+offset never truncate
    always_comb begin
        w_offset_ext = CW'(md_rx_offset);
        w_size_ext   = CW'(md_rx_size);
        w_end        = w_offset_ext + w_size_ext;
        w_base       = C_BYTES + w_offset_ext;
        w_div        = (md_rx_size == '0) ? C_DIV_ONE : w_size_ext;
        w_legal      = (md_rx_size != '0) && (w_end <= C_BYTES) && ((w_base % w_div) == '0);
        w_drop       = (r_state == IDLE) && md_rx_valid && !w_legal;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= IDLE;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_offset <= '0;
            r_size   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md_rx_valid) begin
                        r_data   <= md_rx_data;
                        r_offset <= md_rx_offset;
                        r_size   <= md_rx_size;
                        r_err    <= !w_legal;
                        r_state  <= w_legal ? PUSH : RSP;
                    end
                end
                PUSH: begin
                    if (push_ready) begin
                        r_err   <= 1'b0;
                        r_state <= RSP;
                    end
                end
                RSP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle drop; that drop is intentionally lost
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt <= '0;
        end else if (ctrl_clr) begin
            r_cnt <= '0;
        end else if (w_drop) begin
`ifdef CFS_RX_CTRL_DROP_SAT_EN
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
`else
            r_cnt <= r_cnt + C_CNT_ONE;
`endif
        end
    end

    always_comb begin
        md_rx_ready     = (r_state == RSP);
        md_rx_err       = md_rx_ready && r_err;
        push_valid      = (r_state == PUSH);
        push_data       = r_data;
        push_offset     = r_offset;
        push_size       = r_size;
        status_cnt_drop = r_cnt;
        max_drop        = &r_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_cfs_rx_ctrl.sv
// tb_cfs_rx_ctrl: table-driven and scoreboard bench for cfs_rx_ctrl (32-bit data, 8-bit drop counter).
`timescale 1ns/1ps
`default_nettype none

module tb_cfs_rx_ctrl;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        md_rx_valid = 1'b0;
    logic [31:0] md_rx_data = '0;
    logic [1:0]  md_rx_offset = '0;
    logic [2:0]  md_rx_size = '0;
    logic        md_rx_ready;
    logic        md_rx_err;
    logic        push_valid;
    logic [31:0] push_data;
    logic [1:0]  push_offset;
    logic [2:0]  push_size;
    logic        push_ready = 1'b0;
    logic        ctrl_clr = 1'b0;
    logic [7:0]  status_cnt_drop;
    logic        max_drop;

    cfs_rx_ctrl #(
        .ALGN_DATA_WIDTH       (32),
        .STATUS_CNT_DROP_WIDTH (8)
    ) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .md_rx_valid     (md_rx_valid),
        .md_rx_data      (md_rx_data),
        .md_rx_offset    (md_rx_offset),
        .md_rx_size      (md_rx_size),
        .md_rx_ready     (md_rx_ready),
        .md_rx_err       (md_rx_err),
        .push_valid      (push_valid),
        .push_data       (push_data),
        .push_offset     (push_offset),
        .push_size       (push_size),
        .push_ready      (push_ready),
        .ctrl_clr        (ctrl_clr),
        .status_cnt_drop (status_cnt_drop),
        .max_drop        (max_drop)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [1:0]  off;
        logic [2:0]  size;
        logic [31:0] data;
        bit          legal;
    } vec_t;

    vec_t vecs[16];
    vec_t sbq[$];

    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    logic [7:0] m_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pushes must match the oldest outstanding transfer; acks retire it
    always @(negedge pclk) begin
        if (mon_en) begin
            if (push_valid) begin
                if (sbq.size() == 0) begin
                    check("push_unexpected", 32'd1, 32'd0);
                end else begin
                    check("push_legal", 32'(push_valid), 32'(sbq[0].legal));
                    check("push_data", push_data, sbq[0].data);
                    check("push_offset", 32'(push_offset), 32'(sbq[0].off));
                    check("push_size", 32'(push_size), 32'(sbq[0].size));
                end
            end
            if (md_rx_ready) begin
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    check("ack_err", 32'(md_rx_err), 32'(!sbq[0].legal));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic model_drop(input bit clr);
        if (clr) begin
            m_cnt = '0;
        end else begin
`ifdef CFS_RX_CTRL_DROP_SAT_EN
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
`else
            m_cnt = m_cnt + 8'd1;
`endif
        end
    endtask

    task automatic xfer(input logic [1:0] off, input logic [2:0] size, input logic [31:0] data,
                        input bit legal, input int stall, input bit clr);
        vec_t e;
        int   i;
        int   pv;
        bit   got;
        @(negedge pclk);
        md_rx_valid  = 1'b1;
        md_rx_offset = off;
        md_rx_size   = size;
        md_rx_data   = data;
        push_ready   = 1'b0;
        ctrl_clr     = clr;
        e.off = off; e.size = size; e.data = data; e.legal = legal;
        sbq.push_back(e);
        if (clr) model_drop(1'b1);
        else if (!legal) model_drop(1'b0);
        i = 0; pv = 0; got = 1'b0;
        while (!got && i < 60) begin
            @(negedge pclk);
            i++;
            ctrl_clr = 1'b0;
            if (md_rx_ready) begin
                got = 1'b1;
            end else begin
                if (push_valid) pv++;
                push_ready = (i >= stall + 1);
            end
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_latency", 32'(i), legal ? 32'(stall + 2) : 32'd1);
            check("push_cycles", 32'(pv), legal ? 32'(stall + 1) : 32'd0);
            check("cnt_drop", 32'(status_cnt_drop), 32'(m_cnt));
            check("max_drop", 32'(max_drop), 32'(m_cnt == 8'hFF));
        end
        md_rx_valid = 1'b0;
        push_ready  = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge pclk);
        ctrl_clr = 1'b1;
        @(negedge pclk);
        ctrl_clr = 1'b0;
        m_cnt = '0;
        check("clr_cnt", 32'(status_cnt_drop), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(md_rx_ready), 32'd0);
        check({tag, "_err"}, 32'(md_rx_err), 32'd0);
        check({tag, "_pvalid"}, 32'(push_valid), 32'd0);
        check({tag, "_pdata"}, push_data, 32'd0);
        check({tag, "_poff"}, 32'(push_offset), 32'd0);
        check({tag, "_psize"}, 32'(push_size), 32'd0);
        check({tag, "_cnt"}, 32'(status_cnt_drop), 32'd0);
        check({tag, "_max"}, 32'(max_drop), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Legality derived by hand for BYTES=4
        vecs[0]  = '{2'd1, 3'd1, 32'hAABBCCDD, 1'b1};
        vecs[1]  = '{2'd0, 3'd0, 32'h11111111, 1'b0};
        vecs[2]  = '{2'd1, 3'd2, 32'h22222222, 1'b0};
        vecs[3]  = '{2'd3, 3'd2, 32'h33333333, 1'b0};
        vecs[4]  = '{2'd0, 3'd4, 32'h44444444, 1'b1};
        vecs[5]  = '{2'd2, 3'd2, 32'h55555555, 1'b1};
        vecs[6]  = '{2'd0, 3'd2, 32'h66666666, 1'b1};
        vecs[7]  = '{2'd3, 3'd1, 32'h77777777, 1'b1};
        vecs[8]  = '{2'd1, 3'd3, 32'h88888888, 1'b0};
        vecs[9]  = '{2'd0, 3'd3, 32'h99999999, 1'b0};
        vecs[10] = '{2'd2, 3'd3, 32'hAAAAAAAA, 1'b0};
        vecs[11] = '{2'd1, 3'd4, 32'hBBBBBBBB, 1'b0};
        vecs[12] = '{2'd0, 3'd5, 32'hCCCCCCCC, 1'b0};
        vecs[13] = '{2'd0, 3'd7, 32'hDDDDDDDD, 1'b0};
        vecs[14] = '{2'd2, 3'd1, 32'hEEEEEEEE, 1'b1};
        vecs[15] = '{2'd0, 3'd1, 32'h0F0F0F0F, 1'b1};

        repeat (2) @(negedge pclk);
        check_all_zero("rst");
        presetn = 1'b1;
        mon_en  = 1'b1;

        for (int v = 0; v < 16; v++) begin
            xfer(vecs[v].off, vecs[v].size, vecs[v].data, vecs[v].legal, 0, 1'b0);
        end

        // FIFO backpressure: five refused cycles before acceptance
        xfer(2'd0, 3'd4, 32'h12345678, 1'b1, 5, 1'b0);

        // Saturate or wrap after 256 drops
        clr_pulse();
        for (int k = 0; k < 256; k++) begin
            xfer(2'd0, 3'd0, 32'(k), 1'b0, 0, 1'b0);
        end
`ifdef CFS_RX_CTRL_DROP_SAT_EN
        check("sat_cnt", 32'(status_cnt_drop), 32'd255);
        check("sat_max", 32'(max_drop), 32'd1);
`else
        check("wrap_cnt", 32'(status_cnt_drop), 32'd0);
        check("wrap_max", 32'(max_drop), 32'd0);
`endif

        // Clear coinciding with a drop
        clr_pulse();
        for (int k = 0; k < 5; k++) begin
            xfer(2'd1, 3'd2, 32'hDEAD0000 + 32'(k), 1'b0, 0, 1'b0);
        end
        check("pre_clr_cnt", 32'(status_cnt_drop), 32'd5);
        xfer(2'd1, 3'd2, 32'hDEAD0005, 1'b0, 0, 1'b1);
        check("clr_vs_drop", 32'(status_cnt_drop), 32'd0);
        xfer(2'd3, 3'd2, 32'hDEAD0006, 1'b0, 0, 1'b0);
        check("after_clr", 32'(status_cnt_drop), 32'd1);

        // Asynchronous reset while holding a push
        @(negedge pclk);
        md_rx_valid  = 1'b1;
        md_rx_offset = 2'd0;
        md_rx_size   = 3'd4;
        md_rx_data   = 32'hCAFEF00D;
        push_ready   = 1'b0;
        sbq.push_back('{2'd0, 3'd4, 32'hCAFEF00D, 1'b1});
        repeat (2) @(negedge pclk);
        check("pre_rst_pvalid", 32'(push_valid), 32'd1);
        #1 presetn = 1'b0;
        #1;
        check_all_zero("async_rst");
        sbq.delete();
        md_rx_valid = 1'b0;
        m_cnt = '0;
        @(negedge pclk);
        presetn = 1'b1;
        xfer(2'd1, 3'd1, 32'h0BADBEEF, 1'b1, 0, 1'b0);

        repeat (2) @(negedge pclk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
